// File: rtl/tk2_sched.sv
// tk2_sched: control sequencer for the serial TK2 tweakey register of the
// Romulus-N1 SKINNY-128-384 datapath. It loads 16 tweakey bytes, streams the
// round-tweakey half per round under valid/ready, steps the key schedule after
// each round and issues the closing correction.
// Optional feature: define TK2_SCHED_ABORT_EN to add the `abort` input, which
// drops any busy operation back to IDLE.
module tk2_sched #(
  parameter int ROUNDS   = 40,
  parameter int RW       = 6,
  parameter int CORR_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          di_valid,
  output logic          di_ready,
  input  logic          go,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic          rk_last,
  output logic [RW-1:0] round,
  output logic          busy,
  output logic          armed,
  output logic          done,
  output logic          ksch,
  output logic          chain,
  output logic          in_sel,
  output logic          correct
`ifdef TK2_SCHED_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARMED  = 3'd2,
    S_STREAM = 3'd3,
    S_KSCH   = 3'd4,
    S_CORR   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] round_q, round_d;
  logic          abort_s;

`ifdef TK2_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign round = round_q;

  // Output decode from the registered state; chain also follows the live handshake inputs.
  always_comb begin
    di_ready = 1'b0;
    in_sel   = 1'b0;
    chain    = 1'b0;
    rk_valid = 1'b0;
    rk_last  = 1'b0;
    busy     = 1'b0;
    armed    = 1'b0;
    done     = 1'b0;
    ksch     = 1'b0;
    correct  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        busy     = 1'b1;
        di_ready = 1'b1;
        in_sel   = 1'b1;
        chain    = di_valid;
      end
      S_ARMED: begin
        armed = 1'b1;
      end
      S_STREAM: begin
        busy     = 1'b1;
        chain    = rk_ready;
        // Bytes 0..7 are the round-tweakey half; 8..15 only rotate past.
        rk_valid = ~cnt_q[3];
        rk_last  = (cnt_q == 4'd7);
      end
      S_KSCH: begin
        busy = 1'b1;
        ksch = 1'b1;
      end
      S_CORR: begin
        busy    = 1'b1;
        correct = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Next-state and counter update; an abort of a busy operation overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (di_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_ARMED;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_ARMED: begin
        // A reload request takes priority over starting a block.
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
        end else if (go) begin
          state_d = S_STREAM;
          cnt_d   = 4'd0;
          round_d = {RW{1'b0}};
        end else begin
          state_d = S_ARMED;
        end
      end
      S_STREAM: begin
        if (rk_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_KSCH;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_KSCH: begin
        cnt_d = 4'd0;
        if (round_q == RW'(ROUNDS - 1)) begin
          state_d = S_CORR;
        end else begin
          state_d = S_STREAM;
          round_d = round_q + RW'(1);
        end
      end
      S_CORR: begin
        if (cnt_q == 4'(CORR_CYC - 1)) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_CORR;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        // round keeps ROUNDS-1 until the next block starts.
        state_d = S_ARMED;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        round_d = {RW{1'b0}};
      end
    endcase
    if (abort_s && busy) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      round_d = {RW{1'b0}};
    end else begin
      state_d = state_d;
    end
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      round_q <= {RW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_tk2_sched.sv
// Self-checking bench for tk2_sched. A behavioural TK2 register model follows
// the strobes; expected events are queued when stimulus is applied and compared
// against the events the monitor records.
module tb_tk2_sched;
  localparam int ROUNDS = 40;
  localparam int RW = 6;
  localparam int CORR_CYC = 1;

  logic clk = 1'b0;
  logic rst, load_req, di_valid, go, rk_ready;
  logic di_ready, rk_valid, rk_last, busy, armed, done, ksch, chain, in_sel, correct;
  logic [RW-1:0] round;
  logic [7:0] di_byte;
`ifdef TK2_SCHED_ABORT_EN
  logic abort;
`endif

  tk2_sched #(.ROUNDS(ROUNDS), .RW(RW), .CORR_CYC(CORR_CYC)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .di_valid(di_valid), .di_ready(di_ready),
    .go(go), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .round(round),
    .busy(busy), .armed(armed), .done(done), .ksch(ksch), .chain(chain),
    .in_sel(in_sel), .correct(correct)
`ifdef TK2_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {di_ready, rk_valid, rk_last, busy, armed, done, ksch, chain, in_sel, correct};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] L [16];
  logic [7:0] m [16];
  logic [7:0] tmp_b;

  // observed events
  int obs_ksch[$], obs_kround[$], obs_done[$], obs_corr[$], obs_last[$];
  logic [7:0] obs_rk[$];
  int chain_cnt = 0, excl_err = 0, stall_chain = 0;
  // expected events
  int exp_ksch[$], exp_kround[$], exp_done[$], exp_corr[$], exp_last[$];
  logic [7:0] exp_rk[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus TK2 register model: values at the negedge are those the next posedge acts on.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ksch) begin obs_ksch.push_back(cyc); obs_kround.push_back(int'(round)); end
      if (done) obs_done.push_back(cyc);
      if (correct) obs_corr.push_back(cyc);
      if (rk_valid && rk_ready) obs_rk.push_back(m[15]);
      if (rk_valid && rk_ready && rk_last) obs_last.push_back(cyc);
      if (chain) chain_cnt++;
      if ((32'(ksch) + 32'(chain) + 32'(correct)) > 32'd1) excl_err++;
      if (in_sel && !di_ready) excl_err++;
      if (chain && !in_sel && !rk_ready) stall_chain++;
      if (chain && in_sel) begin
        for (int i = 15; i > 0; i--) m[i] = m[i-1];
        m[0] = di_byte;
      end else if (chain) begin
        tmp_b = m[15];
        for (int i = 15; i > 0; i--) m[i] = m[i-1];
        m[0] = tmp_b;
      end else if (ksch) begin
        for (int i = 0; i < 16; i++) m[i] = m[i] + 8'd1;
      end else if (correct) begin
        for (int i = 0; i < 16; i++) m[i] = m[i] ^ 8'hFF;
      end
    end
  end

  task automatic do_load(input bit gaps, input bit with_go, output int s, output int arm_cyc);
    int idx;
    @(posedge clk); #1;
    s = cyc; load_req = 1'b1; go = with_go; di_valid = 1'b0;
    @(posedge clk); #1;
    load_req = 1'b0; go = 1'b0; idx = 0; arm_cyc = -1;
    for (int k = 0; k < 80; k++) begin
      di_valid = (idx < 16) && (!gaps || (k % 2 == 0));
      di_byte = (idx < 16) ? L[idx] : 8'h00;
      @(negedge clk);
      if (armed) begin arm_cyc = cyc; break; end
      if (di_valid && di_ready) idx++;
      @(posedge clk); #1;
    end
    di_valid = 1'b0;
  endtask

  task automatic do_block(input logic [14:0] stall_mask, input bit poke, output int t);
    int nst;
    nst = $countones(stall_mask);
    @(posedge clk); #1;
    t = cyc; go = 1'b1; rk_ready = 1'b1;
    obs_ksch.delete(); obs_kround.delete(); obs_done.delete(); obs_corr.delete();
    obs_last.delete(); obs_rk.delete();
    exp_ksch.delete(); exp_kround.delete(); exp_done.delete(); exp_corr.delete();
    exp_last.delete(); exp_rk.delete();
    for (int r = 0; r < ROUNDS; r++) begin
      exp_ksch.push_back(t + 17 + 17*r + ((r >= 3) ? nst : 0));
      exp_kround.push_back(r);
      if (nst == 0) exp_last.push_back(t + 8 + 17*r);
      for (int i = 0; i < 8; i++) exp_rk.push_back(L[i] + 8'(r));
    end
    for (int j = 0; j < CORR_CYC; j++) exp_corr.push_back(t + 1 + 17*ROUNDS + j + nst);
    exp_done.push_back(t + 1 + 17*ROUNDS + CORR_CYC + nst);
    @(posedge clk); #1;
    go = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      rk_ready = !((k >= 52 && k <= 66) ? stall_mask[k-52] : 1'b0);
      go = poke && (k == 40);
      load_req = poke && (k == 40);
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
    end
    go = 1'b0; load_req = 1'b0; rk_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; di_valid = 1'b0; go = 1'b0; rk_ready = 1'b0; di_byte = 8'h00;
`ifdef TK2_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (outs !== 10'd0) begin n_fail++; $display("FAIL reset_outs: got %b, expected 0", outs); end
    n_checks++; if (round !== 6'd0) begin n_fail++; $display("FAIL reset_round: got %0d, expected 0", round); end
    @(posedge clk); #1;
    rst = 1'b0; go = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin n_fail++; $display("FAIL idle_go_ignored: got busy=%b rk_valid=%b, expected 0 0", busy, rk_valid); end
  endtask

  task automatic test_load(input bit gaps);
    int s, a, c0, want;
    c0 = chain_cnt;
    do_load(gaps, 1'b0, s, a);
    want = gaps ? s + 32 : s + 17;
    n_checks++; if (a !== want) begin n_fail++; $display("FAIL load_armed_cycle(gaps=%0d): got %0d, expected %0d", gaps, a, want); end
    n_checks++; if (chain_cnt - c0 !== 16) begin n_fail++; $display("FAIL load_chain_count: got %0d, expected 16", chain_cnt - c0); end
    n_checks++; if (di_ready !== 1'b0 || in_sel !== 1'b0) begin n_fail++; $display("FAIL load_ready_after: got di_ready=%b in_sel=%b, expected 0 0", di_ready, in_sel); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (m[15-i] !== L[i]) begin n_fail++; $display("FAIL load_byte%0d: got %h, expected %h", i, m[15-i], L[i]); end
    end
  endtask

  task automatic test_full_block();
    int s, a, t, e, o, c0;
    logic [7:0] eb, ob;
    do_load(1'b0, 1'b0, s, a);
    c0 = excl_err;
    do_block(15'd0, 1'b1, t);
    n_checks++; if (obs_ksch.size() !== 40) begin n_fail++; $display("FAIL full_ksch_count: got %0d, expected 40", obs_ksch.size()); end
    while (exp_ksch.size() > 0 && obs_ksch.size() > 0) begin
      e = exp_ksch.pop_front(); o = obs_ksch.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_ksch_cycle: got %0d, expected %0d", o - t, e - t); end
      e = exp_kround.pop_front(); o = obs_kround.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_ksch_round: got %0d, expected %0d", o, e); end
    end
    n_checks++; if (obs_rk.size() !== 320) begin n_fail++; $display("FAIL full_rk_count: got %0d, expected 320", obs_rk.size()); end
    while (exp_rk.size() > 0 && obs_rk.size() > 0) begin
      eb = exp_rk.pop_front(); ob = obs_rk.pop_front();
      n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL full_rk_byte: got %h, expected %h", ob, eb); end
    end
    n_checks++; if (obs_last.size() !== 40) begin n_fail++; $display("FAIL full_last_count: got %0d, expected 40", obs_last.size()); end
    while (exp_last.size() > 0 && obs_last.size() > 0) begin
      e = exp_last.pop_front(); o = obs_last.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_last_cycle: got %0d, expected %0d", o - t, e - t); end
    end
    n_checks++; if (obs_corr.size() !== CORR_CYC) begin n_fail++; $display("FAIL full_corr_count: got %0d, expected %0d", obs_corr.size(), CORR_CYC); end
    while (exp_corr.size() > 0 && obs_corr.size() > 0) begin
      e = exp_corr.pop_front(); o = obs_corr.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_corr_cycle: got %0d, expected %0d", o - t, e - t); end
    end
    e = exp_done.pop_front(); o = (obs_done.size() > 0) ? obs_done.pop_front() : -1;
    n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_done_cycle: got %0d, expected %0d", o - t, e - t); end
    n_checks++; if (excl_err - c0 !== 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d violations, expected 0", excl_err - c0); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (armed !== 1'b1 || round !== 6'd39) begin n_fail++; $display("FAIL after_done: got armed=%b round=%0d, expected 1 39", armed, round); end
  endtask

  task automatic test_backpressure();
    int s, a, t, e, o, c0;
    logic [7:0] eb, ob;
    logic [14:0] mask;
    mask = 15'd0;
    while ($countones(mask) < 5) mask[$urandom_range(14, 0)] = 1'b1;
    do_load(1'b0, 1'b0, s, a);
    c0 = stall_chain;
    do_block(mask, 1'b0, t);
    n_checks++; if (stall_chain - c0 !== 0) begin n_fail++; $display("FAIL bp_chain_in_stall: got %0d, expected 0", stall_chain - c0); end
    n_checks++; if (obs_ksch.size() !== 40) begin n_fail++; $display("FAIL bp_ksch_count: got %0d, expected 40", obs_ksch.size()); end
    while (exp_ksch.size() > 0 && obs_ksch.size() > 0) begin
      e = exp_ksch.pop_front(); o = obs_ksch.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL bp_ksch_cycle: got %0d, expected %0d", o - t, e - t); end
    end
    n_checks++; if (obs_rk.size() !== 320) begin n_fail++; $display("FAIL bp_rk_count: got %0d, expected 320", obs_rk.size()); end
    while (exp_rk.size() > 0 && obs_rk.size() > 0) begin
      eb = exp_rk.pop_front(); ob = obs_rk.pop_front();
      n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL bp_rk_byte: got %h, expected %h", ob, eb); end
    end
    e = exp_done.pop_front(); o = (obs_done.size() > 0) ? obs_done.pop_front() : -1;
    n_checks++; if (o !== e) begin n_fail++; $display("FAIL bp_done_cycle: got %0d, expected %0d", o - t, e - t); end
  endtask

  task automatic test_priority();
    int s, a, c0;
    obs_ksch.delete();
    c0 = chain_cnt;
    do_load(1'b0, 1'b1, s, a);
    n_checks++; if (a !== s + 17) begin n_fail++; $display("FAIL prio_load_wins: got armed at %0d, expected %0d", a, s + 17); end
    n_checks++; if (chain_cnt - c0 !== 16 || obs_ksch.size() !== 0) begin n_fail++; $display("FAIL prio_no_stream: got chain=%0d ksch=%0d, expected 16 0", chain_cnt - c0, obs_ksch.size()); end
  endtask

  task automatic test_stop(input bit use_abort, input int rnd);
    int s, a, t;
    do_load(1'b0, 1'b0, s, a);
    @(posedge clk); #1;
    t = cyc; go = 1'b1; rk_ready = 1'b1; obs_done.delete();
    @(posedge clk); #1;
    go = 1'b0;
    for (int k = 1; k < 17*rnd + 5; k++) begin @(posedge clk); #1; end
`ifdef TK2_SCHED_ABORT_EN
    if (use_abort) abort = 1'b1; else rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || round !== 6'(rnd)) begin n_fail++; $display("FAIL stop_pre(r%0d): got busy=%b round=%0d, expected 1 %0d", rnd, busy, round, rnd); end
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef TK2_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    n_checks++; if (outs !== 10'd0 || round !== 6'd0) begin n_fail++; $display("FAIL stop_idle(r%0d): got outs=%b round=%0d, expected 0 0", rnd, outs, round); end
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || armed !== 1'b0 || obs_done.size() !== 0) begin n_fail++; $display("FAIL stop_go_ignored(r%0d): got busy=%b armed=%b dones=%0d, expected 0 0 0", rnd, busy, armed, obs_done.size()); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) L[i] = 8'(i);
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_full_block();
    test_backpressure();
    test_priority();
    test_stop(1'b0, 10);
`ifdef TK2_SCHED_ABORT_EN
    test_stop(1'b1, 5);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
